// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter for VGA_controller: display fetch > clear engine > external
// writer, plus a word-to-pixel serialiser and sync delay line matched to the 3-cycle pixel latency.
module vga_fb_arbiter #(
    parameter int H_PIX  = 512,
    parameter int V_PIX  = 480,
    parameter int PIX_W  = 2,
    parameter int PPW    = 8,
    parameter int ADDR_W = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_hs,
    input  logic                 i_vs,
    input  logic                 i_de,
    input  logic [8:0]           i_x,
    input  logic [8:0]           i_y,
    output logic                 o_ram_en,
    output logic                 o_ram_we,
    output logic [ADDR_W-1:0]    o_ram_addr,
    output logic [PIX_W*PPW-1:0] o_ram_wdata,
    input  logic [PIX_W*PPW-1:0] i_ram_rdata,
    input  logic                 i_wr_valid,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [PIX_W*PPW-1:0] i_wr_data,
    output logic                 o_wr_ready,
    output logic                 o_wr_err,
    input  logic                 i_clear,
    input  logic [PIX_W-1:0]     i_clear_color,
    output logic                 o_busy,
    output logic [PIX_W-1:0]     o_pix,
    output logic                 o_hs_d,
    output logic                 o_vs_d,
    output logic                 o_de_d
);
    localparam int DATA_W = PIX_W * PPW;
    localparam int WPL    = H_PIX / PPW;
    localparam int WORDS  = WPL * V_PIX;
    localparam int PPW_LG = $clog2(PPW);

    localparam logic [ADDR_W:0]   WORDS_EXT = (ADDR_W + 1)'(WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] clr_word_q, clr_word_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              wr_err_q, wr_err_d;
    logic [2:0]        hs_pipe_q, hs_pipe_d;
    logic [2:0]        vs_pipe_q, vs_pipe_d;
    logic [2:0]        de_pipe_q, de_pipe_d;
    logic [1:0]        rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] sh_q, sh_d;

    logic              display_slot;
    logic              wr_fire;
    logic              wr_in_range;
    logic [ADDR_W-1:0] rd_addr;

    assign display_slot = i_de && (i_x[PPW_LG-1:0] == '0);
    assign rd_addr      = ADDR_W'(i_y) * ADDR_W'(WPL) + ADDR_W'(i_x >> PPW_LG);
    assign o_wr_ready   = !display_slot && (state_q == ST_IDLE);
    assign wr_fire      = i_wr_valid && o_wr_ready;
    assign wr_in_range  = {1'b0, i_wr_addr} < WORDS_EXT;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_word_d  = clr_word_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        wr_err_d    = 1'b0;

        if (display_slot) begin
            ram_en_d   = 1'b1;
            ram_addr_d = rd_addr;
        end else if (state_q == ST_CLEAR) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = cnt_q;
            ram_wdata_d = clr_word_q;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_IDLE;
            end
        end else if (wr_fire) begin
            if (wr_in_range) begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = i_wr_addr;
                ram_wdata_d = i_wr_data;
            end else begin
                wr_err_d = 1'b1;
            end
        end

        // A same-cycle writer transfer still goes out; the clear begins next cycle.
        if ((state_q == ST_IDLE) && i_clear) begin
            state_d    = ST_CLEAR;
            cnt_d      = '0;
            clr_word_d = {PPW{i_clear_color}};
        end

        // Read data returns two cycles after the slot; reload exactly as the last pixel leaves.
        rd_vld_d  = {rd_vld_q[0], display_slot};
        sh_d      = rd_vld_q[1] ? i_ram_rdata : (sh_q >> PIX_W);
        hs_pipe_d = {hs_pipe_q[1:0], i_hs};
        vs_pipe_d = {vs_pipe_q[1:0], i_vs};
        de_pipe_d = {de_pipe_q[1:0], i_de};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            clr_word_q  <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            wr_err_q    <= 1'b0;
            hs_pipe_q   <= '1;
            vs_pipe_q   <= '1;
            de_pipe_q   <= '0;
            rd_vld_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_word_q  <= clr_word_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            wr_err_q    <= wr_err_d;
            hs_pipe_q   <= hs_pipe_d;
            vs_pipe_q   <= vs_pipe_d;
            de_pipe_q   <= de_pipe_d;
            rd_vld_q    <= rd_vld_d;
        end
        sh_q <= sh_d;
    end

    assign o_ram_en    = ram_en_q;
    assign o_ram_we    = ram_we_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_wdata = ram_wdata_q;
    assign o_wr_err    = wr_err_q;
    assign o_busy      = (state_q == ST_CLEAR);
    assign o_hs_d      = hs_pipe_q[2];
    assign o_vs_d      = vs_pipe_q[2];
    assign o_de_d      = de_pipe_q[2];
    assign o_pix       = de_pipe_q[2] ? sh_q[PIX_W-1:0] : '0;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Owns the single-port framebuffer RAM behind `VGA_controller`. It shares the RAM between three requesters, in fixed priority order: display fetch, a built-in clear engine, and an external writer port. The block fetches packed pixel words in step with the controller's raster position and serialises them into a pixel stream. It also delays the sync signals so that they stay aligned with that stream.

## Interface
Parameters:
- `H_PIX`, 512: active pixels per line; must be a multiple of `PPW`.
- `V_PIX`, 480: active lines.
- `PIX_W`, 2: bits per pixel.
- `PPW`, 8: pixels per RAM word; must be a power of two.
- `ADDR_W`, 15: RAM word address width; must satisfy 2^ADDR_W ≥ WORDS.
- Derived: `DATA_W` = PIX_W*PPW = 16. `WPL` = H_PIX/PPW = 64 words per line. `WORDS` = WPL*V_PIX = 30720.

Ports:
- `clk`, in, 1: pixel clock. Same clock as `VGA_controller`.
- `rst`, in, 1: reset, synchronous, active-low.
- `i_hs`, `i_vs`, in, 1 each: syncs from `VGA_controller`, active-low.
- `i_de`, in, 1: high while (x,y) is inside the 512×480 active area.
- `i_x`, in, 9: current pixel x, valid when `i_de`=1.
- `i_y`, in, 9: current pixel y, valid when `i_de`=1.
- `o_ram_en`, out, 1: RAM access strobe.
- `o_ram_we`, out, 1: write enable, qualified by `o_ram_en`.
- `o_ram_addr`, out, ADDR_W: RAM word address.
- `o_ram_wdata`, out, DATA_W: RAM write data.
- `i_ram_rdata`, in, DATA_W: RAM read data, valid one cycle after a read strobe.
- `i_wr_valid`, in, 1: writer request.
- `i_wr_addr`, in, ADDR_W: writer word address.
- `i_wr_data`, in, DATA_W: writer data.
- `o_wr_ready`, out, 1: writer may transfer this cycle. Combinational.
- `o_wr_err`, out, 1: one-cycle pulse; an accepted write had an address ≥ WORDS.
- `i_clear`, in, 1: start-clear pulse.
- `i_clear_color`, in, PIX_W: fill colour, sampled on the cycle `i_clear` is accepted.
- `o_busy`, out, 1: clear in progress.
- `o_pix`, out, PIX_W: pixel output.
- `o_hs_d`, `o_vs_d`, `o_de_d`, out, 1 each: `i_hs`/`i_vs`/`i_de` delayed by 3 cycles.

## Operation
- **Display slot.** A cycle is a display slot when `i_de`=1 and `i_x` mod PPW = 0.
  - Read address is i_y*WPL + i_x/PPW.
  - The display slot has absolute priority.
- **Clear FSM.** States are IDLE and CLEAR.
  - IDLE→CLEAR when `i_clear`=1. This latches the colour, replicated PPW times, and sets the clear counter to 0.
  - In CLEAR, every non-display cycle writes the replicated colour at the counter address, then increments the counter.
  - CLEAR→IDLE on the cycle that issues the write at WORDS-1.
  - `i_clear` in CLEAR is ignored.
- **Writer.** `o_wr_ready` = ~display_slot & (state==IDLE).
  - A transfer happens when `i_wr_valid` & `o_wr_ready`.
  - If the address is < WORDS, a RAM write is issued.
  - Otherwise no RAM access is made and `o_wr_err` pulses.
- **Serialiser.** A DATA_W shift register outputs pixel 0 from bits [PIX_W-1:0] (LSB first), shifting right by PIX_W each cycle.
  - It loads `i_ram_rdata` on the cycle that read data returns.
  - `o_pix` = 0 whenever `o_de_d`=0.
- **Reset** (`rst`=0 at a clock edge):
  - State goes to IDLE and any clear is aborted.
  - `o_ram_en`, `o_ram_we`, `o_ram_addr`, `o_ram_wdata`, `o_wr_err`, `o_busy`, `o_pix`, `o_de_d` go to 0.
  - `o_hs_d` and `o_vs_d` go to 1.
  - The delay pipelines are flushed to the inactive values.

## Timing
- **RAM outputs are registered.** A request decided in cycle t appears on `o_ram_*` in cycle t+1. For reads, `i_ram_rdata` is valid in t+2.
- **Pixel latency is 3 cycles.**
  - Display slot at t → shift register loaded at the end of t+2.
  - Pixel x appears on `o_pix` at t+3, aligned with `o_de_d`.
  - Pixels x+1…x+PPW-1 follow on consecutive cycles.
  - The next word loads exactly when the previous word is exhausted, so there are no bubbles within a line.
- **Writer throughput.** In the active area the writer gets at most PPW-1 of every PPW cycles. In blanking it gets every cycle.
- **Writer pulses.** An accepted write drives `o_ram_en`=`o_ram_we`=1 for exactly one cycle, at t+1. `o_wr_err` is also asserted at t+1.
- **`o_busy` timing.** `o_busy` rises the cycle after `i_clear` is accepted. It falls the cycle after the last clear write is issued.
- **Simultaneous writer and clear.** If `i_wr_valid` and `i_clear` arrive in the same IDLE cycle, the writer transfer is accepted (ready is still 1) and the clear starts next cycle.
- **Idle cycles.** When nobody is granted, `o_ram_en`=0. `o_ram_addr` and `o_ram_wdata` hold their previous values.

## Test plan
- **Reset values.** Hold `rst`=0 for 2 cycles with arbitrary inputs → all outputs at their reset values; `o_hs_d`=`o_vs_d`=1; `o_ram_en`=0.
- **Display fetch.** Preload word 0x0000=16'hE4E4, then drive `i_de`=1, `i_x`=0..7, `i_y`=0 → read of address 0 at t+1; `o_pix` sequence 0,1,2,3,0,1,2,3 starting at t+3.
- **Line address.** `i_y`=479, `i_x`=504 → `o_ram_addr`=30719 on the following cycle.
- **Writer arbitration.** Hold `i_wr_valid`=1 across active cycles `i_x`=0..15 → `o_wr_ready`=0 exactly at `i_x`=0 and 8; 14 writes accepted, each RAM write one cycle after acceptance.
- **Writer address error.** Write with `i_wr_addr`=30720 → accepted; no RAM write; one `o_wr_err` pulse.
- **Clear.**
  - `i_clear` with colour 2'b11 during vertical blanking → 30720 writes of 16'hFFFF at addresses 0..30719 in order.
  - `o_busy` is high throughout and `o_wr_ready`=0.
  - Repeat with `rst` pulsed mid-clear → `o_busy`=0 and no further writes.
